com_rx: RTL

//  Link-side receiver and packet parser; the far-end peer of the byte transmitter in the com path.

---
 rtl/com_rx.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/com_rx.sv
// com_rx: byte-per-cycle link receiver. Hunts for SYNC, decodes PID, length,
// payload and CRC, writes payload bytes to RAM and reports the packet type,
// length and error flags to the controller over the fs/fd level handshake.
// CRC definitions (MSB-first, no final xor):
//   crc5 : poly x^5+x^2+1 (5'h05), init 5'h1F, reported zero-extended to 8 bits
//   crc16: poly x^16+x^15+x^2+1 (16'h8005), init 16'hFFFF
module com_rx #(
  parameter logic [11:0] MAX_LEN  = 12'h800,
  parameter logic [11:0] ADDR_RST = 12'hFF0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fs,
  output logic        fd,
  input  logic [7:0]  com_rxd,
  input  logic [11:0] ram_addr_init,
  output logic [11:0] ram_txa,
  output logic [7:0]  ram_txd,
  output logic        ram_txe,
  output logic [3:0]  btype,
  output logic [11:0] rx_dlen,
  output logic        crc_err,
  output logic        pid_err
);

  localparam logic [7:0]  SYNC       = 8'h0F;
  localparam logic [4:0]  CRC5_POLY  = 5'h05;
  localparam logic [4:0]  CRC5_INIT  = 5'h1F;
  localparam logic [15:0] CRC16_POLY = 16'h8005;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  typedef enum logic [3:0] {
    S_IDLE, S_WAIT, S_HUNT, S_WPID, S_DNUM,
    S_WORK, S_CRC0, S_CRC1, S_CHK,  S_DONE
  } state_t;

  state_t      state;
  logic [11:0] num;          // payload byte index within the packet
  logic [11:0] init_reg;     // RAM base address captured while waiting
  logic        is_stat;      // STAT packets carry a single crc5 byte
  logic        dnum_lo;      // second length byte expected next
  logic [15:0] crc_rx;       // CRC bytes as received
  logic [4:0]  crc5_reg;
  logic [15:0] crc16_reg;
  logic [11:0] dnum_len;     // full length once the low byte arrives

  assign dnum_len = {rx_dlen[11:8], com_rxd};

  // One byte through the crc5 register, MSB first
  function automatic logic [4:0] crc5_next(input logic [4:0] c, input logic [7:0] d);
    logic [4:0] r;
    logic       fb;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      fb = r[4] ^ d[i];
      r  = {r[3:0], 1'b0} ^ (fb ? CRC5_POLY : 5'h00);
    end
    return r;
  endfunction

  // One byte through the crc16 register, MSB first
  function automatic logic [15:0] crc16_next(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    logic        fb;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      fb = r[15] ^ d[i];
      r  = {r[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
    end
    return r;
  endfunction

  // Packet parser FSM with registered outputs and RAM write port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      fd        <= 1'b0;
      ram_txe   <= 1'b0;
      ram_txd   <= 8'h00;
      ram_txa   <= ADDR_RST;
      btype     <= 4'b0000;
      rx_dlen   <= 12'h000;
      crc_err   <= 1'b0;
      pid_err   <= 1'b0;
      num       <= 12'h000;
      init_reg  <= 12'h000;
      is_stat   <= 1'b0;
      dnum_lo   <= 1'b0;
      crc_rx    <= 16'h0000;
      crc5_reg  <= CRC5_INIT;
      crc16_reg <= CRC16_INIT;
    end else begin
      ram_txe <= 1'b0;
      case (state)
        S_IDLE: state <= S_WAIT;
        S_WAIT: begin
          fd        <= 1'b0;
          btype     <= 4'b0000;
          rx_dlen   <= 12'h000;
          crc_err   <= 1'b0;
          pid_err   <= 1'b0;
          num       <= 12'h000;
          dnum_lo   <= 1'b0;
          init_reg  <= ram_addr_init;
          crc5_reg  <= CRC5_INIT;
          crc16_reg <= CRC16_INIT;
          if (fs) state <= S_HUNT;
        end
        S_HUNT: if (com_rxd == SYNC) state <= S_WPID;
        S_WPID: begin
          case (com_rxd)
            8'h2D:   begin btype <= 4'b0001; fd <= 1'b1; state <= S_DONE; end
            8'hA5:   begin btype <= 4'b0010; fd <= 1'b1; state <= S_DONE; end
            8'hE1:   begin btype <= 4'b0011; fd <= 1'b1; state <= S_DONE; end
            8'hD2:   begin btype <= 4'b1000; is_stat <= 1'b1; state <= S_DNUM; end
            8'h96:   begin btype <= 4'b1101; is_stat <= 1'b0; state <= S_DNUM; end
            8'h5A:   begin btype <= 4'b1110; is_stat <= 1'b0; state <= S_DNUM; end
            default: begin btype <= 4'b0000; pid_err <= 1'b1; fd <= 1'b1; state <= S_DONE; end
          endcase
        end
        S_DNUM: begin
          if (!dnum_lo) begin
            rx_dlen[11:8] <= com_rxd[3:0];
            dnum_lo       <= 1'b1;
          end else begin
            rx_dlen[7:0] <= com_rxd;
            if (dnum_len > MAX_LEN) begin
              pid_err <= 1'b1;
              fd      <= 1'b1;
              state   <= S_DONE;
            end else if (dnum_len == 12'h000) begin
              state <= S_CRC0;
            end else begin
              state <= S_WORK;
            end
          end
        end
        S_WORK: begin
          ram_txe   <= 1'b1;
          ram_txd   <= com_rxd;
          ram_txa   <= init_reg + num;
          num       <= num + 12'd1;
          crc5_reg  <= crc5_next(crc5_reg, com_rxd);
          crc16_reg <= crc16_next(crc16_reg, com_rxd);
          if (num == rx_dlen - 12'd1) state <= S_CRC0;
        end
        S_CRC0: begin
          if (is_stat) begin
            crc_rx <= {8'h00, com_rxd};
            state  <= S_CHK;
          end else begin
            crc_rx[15:8] <= com_rxd;
            state        <= S_CRC1;
          end
        end
        S_CRC1: begin
          crc_rx[7:0] <= com_rxd;
          state       <= S_CHK;
        end
        S_CHK: begin
          crc_err <= is_stat ? (crc_rx[7:0] != {3'b000, crc5_reg})
                             : (crc_rx != crc16_reg);
          fd      <= 1'b1;
          state   <= S_DONE;
        end
        S_DONE: begin
          if (!fs) begin
            fd    <= 1'b0;
            state <= S_WAIT;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
